// File: rtl/ddr_wr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_wr_pkg
// Shared definitions for the DDR write path (arbiter and formatter).
//   PKT_LEN_DEF : bytes per packet (address + data)
//   ADDR_BYTES  : leading address bytes of every packet
//   REQ_ECM/SI  : requester IDs, also used as bit positions in req/pick
//   state_t     : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package ddr_wr_pkg;

   localparam int PKT_LEN_DEF = 203;
   localparam int ADDR_BYTES  = 4;

   localparam logic REQ_ECM = 1'b0;
   localparam logic REQ_SI  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_XFER,
      ST_PAD,
      ST_GAP
   } state_t;

endpackage

// File: rtl/ddr_wr_arb_if.sv
// ---------------------------------------------------------------------------
// ddr_wr_arb_if
// Bundle of the requester handshakes, the formatter byte stream and the
// arbiter status/error flags.
//   master : requester/formatter side (drives req, din, din_en)
//   slave  : arbiter side (drives gnt, wr_din, wr_din_en, busy, err_*)
// ---------------------------------------------------------------------------
interface ddr_wr_arb_if;

   logic       ecm_req;
   logic       ecm_gnt;
   logic [7:0] ecm_din;
   logic       ecm_din_en;

   logic       si_req;
   logic       si_gnt;
   logic [7:0] si_din;
   logic       si_din_en;

   logic [7:0] wr_din;
   logic       wr_din_en;

   logic       busy;
   logic       err_pad;
   logic       err_tmo;
   logic       err_col;

   modport master (
      output ecm_req, ecm_din, ecm_din_en,
      output si_req, si_din, si_din_en,
      input  ecm_gnt, si_gnt,
      input  wr_din, wr_din_en,
      input  busy, err_pad, err_tmo, err_col
   );

   modport slave (
      input  ecm_req, ecm_din, ecm_din_en,
      input  si_req, si_din, si_din_en,
      output ecm_gnt, si_gnt,
      output wr_din, wr_din_en,
      output busy, err_pad, err_tmo, err_col
   );

endinterface

// File: rtl/ddr_wr_rr2.sv
// ---------------------------------------------------------------------------
// ddr_wr_rr2
// Two-way round-robin picker, purely combinational. The caller keeps the
// last-served ID in its own register.
//   req[1:0] : request per requester, indexed by REQ_ECM / REQ_SI
//   last     : ID of the requester served most recently
//   pick     : one-hot winner (all zero when nobody requests)
//   pick_id  : ID of the winner (REQ_ECM when nobody requests)
// ---------------------------------------------------------------------------
module ddr_wr_rr2
   import ddr_wr_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick,
   output logic       pick_id
);

   always_comb begin
      pick_id = REQ_ECM;
      if (req[REQ_ECM] && req[REQ_SI]) begin
         // On a tie the requester that was not served last goes first.
         pick_id = (last == REQ_ECM) ? REQ_SI : REQ_ECM;
      end else if (req[REQ_SI]) begin
         pick_id = REQ_SI;
      end

      pick = '0;
      if (|req) begin
         pick[pick_id] = 1'b1;
      end
   end

endmodule

// File: rtl/ddr_wr_arb.sv
// ---------------------------------------------------------------------------
// ddr_wr_arb
// Packet-level arbiter sharing the byte-wide DDR write path between the ECM
// and SI requesters. A granted requester owns the path for one whole packet
// of PKT_LEN bytes; short packets are zero-padded so the formatter always
// sees a contiguous PKT_LEN-byte burst followed by at least GAP idle cycles.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : slave side of ddr_wr_arb_if
//                 ecm_/si_req, din, din_en in ; ecm_/si_gnt out
//                 wr_din, wr_din_en out (registered, one cycle after input)
//                 busy out (state not IDLE)
//                 err_pad / err_tmo / err_col out (one-cycle pulses)
// Parameters: PKT_LEN (>= 2), GAP (>= 1), TIMEOUT (1..128).
// ---------------------------------------------------------------------------
module ddr_wr_arb
   import ddr_wr_pkg::*;
#(
   parameter int PKT_LEN = PKT_LEN_DEF,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   ddr_wr_arb_if.slave bus
);

   localparam int         GAP_W    = $clog2(GAP + 1);
   localparam logic [7:0] LAST_CNT = 8'(PKT_LEN - 1);
   localparam logic [6:0] TMO_CNT  = 7'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP);

   state_t           state;
   logic             owner;
   logic             last;
   logic [7:0]       cnt;
   logic [6:0]       wt;
   logic [GAP_W-1:0] gap_cnt;

   logic [1:0]       pick;
   logic             pick_id;
   logic             sel_en;
   logic [7:0]       sel_din;
   logic             own_ecm;
   logic             own_si;
   logic             col;

   ddr_wr_rr2 u_rr2 (
      .req     ({bus.si_req, bus.ecm_req}),
      .last    (last),
      .pick    (pick),
      .pick_id (pick_id)
   );

   // Only the owner's byte lane is ever forwarded.
   assign sel_en  = (owner == REQ_SI) ? bus.si_din_en : bus.ecm_din_en;
   assign sel_din = (owner == REQ_SI) ? bus.si_din    : bus.ecm_din;

   // A din_en is legitimate only from the owner while it is allowed to send.
   assign own_ecm = ((state == ST_GRANT) || (state == ST_XFER)) && (owner == REQ_ECM);
   assign own_si  = ((state == ST_GRANT) || (state == ST_XFER)) && (owner == REQ_SI);
   assign col     = (bus.ecm_din_en && !own_ecm) || (bus.si_din_en && !own_si);

   assign bus.busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         owner         <= REQ_ECM;
         last          <= REQ_ECM;
         cnt           <= '0;
         wt            <= '0;
         gap_cnt       <= '0;
         bus.ecm_gnt   <= 1'b0;
         bus.si_gnt    <= 1'b0;
         bus.wr_din    <= '0;
         bus.wr_din_en <= 1'b0;
         bus.err_pad   <= 1'b0;
         bus.err_tmo   <= 1'b0;
         bus.err_col   <= 1'b0;
      end else begin
         bus.wr_din    <= '0;
         bus.wr_din_en <= 1'b0;
         bus.err_pad   <= 1'b0;
         bus.err_tmo   <= 1'b0;
         bus.err_col   <= col;

         case (state)
            ST_IDLE: begin
               gap_cnt <= '0;
               if (|pick) begin
                  owner       <= pick_id;
                  bus.ecm_gnt <= pick[REQ_ECM];
                  bus.si_gnt  <= pick[REQ_SI];
                  cnt         <= '0;
                  wt          <= '0;
                  state       <= ST_GRANT;
               end
            end

            ST_GRANT: begin
               if (sel_en) begin
                  bus.wr_din    <= sel_din;
                  bus.wr_din_en <= 1'b1;
                  cnt           <= 8'd1;
                  state         <= ST_XFER;
               end else if (wt == TMO_CNT) begin
                  bus.ecm_gnt <= 1'b0;
                  bus.si_gnt  <= 1'b0;
                  bus.err_tmo <= 1'b1;
                  last        <= owner;
                  state       <= ST_GAP;
               end else begin
                  wt <= wt + 7'd1;
               end
            end

            ST_XFER: begin
               if (sel_en) begin
                  bus.wr_din    <= sel_din;
                  bus.wr_din_en <= 1'b1;
                  cnt           <= cnt + 8'd1;
                  if (cnt == LAST_CNT) begin
                     bus.ecm_gnt <= 1'b0;
                     bus.si_gnt  <= 1'b0;
                     last        <= owner;
                     state       <= ST_GAP;
                  end
               end else begin
                  // The first pad byte goes out in the very cycle the
                  // requester stalls, so the burst has no hole in it.
                  bus.wr_din_en <= 1'b1;
                  bus.err_pad   <= 1'b1;
                  cnt           <= cnt + 8'd1;
                  bus.ecm_gnt   <= 1'b0;
                  bus.si_gnt    <= 1'b0;
                  last          <= owner;
                  state         <= (cnt == LAST_CNT) ? ST_GAP : ST_PAD;
               end
            end

            ST_PAD: begin
               bus.wr_din_en <= 1'b1;
               cnt           <= cnt + 8'd1;
               if (cnt == LAST_CNT) begin
                  state <= ST_GAP;
               end
            end

            ST_GAP: begin
               // The first GAP cycle carries the final byte on the output,
               // so GAP+1 cycles here leave GAP idle cycles on wr_din_en.
               if (gap_cnt == GAP_END) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ddr_wr_arb.md
# ddr_wr_arb

Packet-level arbiter in front of the DDR write formatter. It shares the single byte-wide write path between the ECM and SI requesters. Each requester gets a whole 203-byte packet (4 address bytes, then 199 data bytes) without interleaving. Packets leave on wr_din/wr_din_en as one contiguous burst with a guaranteed idle gap, so the formatter's byte counter always restarts on an address byte.

## Interface
- PKT_LEN, 203: bytes per packet (4 address and 199 data).
- GAP, 1: idle cycles forced on wr_din_en between packets; minimum 1.
- TIMEOUT, 64: cycles a grant waits for the first byte before it is revoked.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ecm_req  in  1  ECM has a packet ready; level signal, held until grant.
- ecm_gnt  out  1  ECM owns the path; high from grant until the last byte is accepted.
- ecm_din  in  8  ECM byte.
- ecm_din_en  in  1  ECM byte valid.
- si_req, si_gnt, si_din, si_din_en: same as the ECM ports, for SI.
- wr_din  out  8  byte to the formatter.
- wr_din_en  out  1  byte valid to the formatter.
- busy  out  1  state is not IDLE.
- err_pad  out  1  one-cycle pulse: packet ended short and was zero-padded.
- err_tmo  out  1  one-cycle pulse: grant revoked on timeout.
- err_col  out  1  one-cycle pulse: a non-granted requester drove din_en.

## Operation
- FSM states: IDLE, GRANT, XFER, PAD, GAP.
- IDLE: if any req is high, pick a winner with the round-robin picker, assert its gnt and go to GRANT.
  - If both are requesting, the requester not served last wins.
  - Reset sets last-served to ECM, so SI wins the first tie.
- GRANT: wait for the winner's din_en.
  - On din_en, forward the byte, set byte count to 1 and go to XFER.
  - If the wait counter reaches TIMEOUT-1 with no din_en: drop gnt, pulse err_tmo, update last-served, go to GAP.
- XFER: each cycle the winner's din_en is high, forward the byte and increment the count.
  - When the forwarded byte is number PKT_LEN (count reaches PKT_LEN): drop gnt, update last-served, go to GAP.
  - If din_en is low while count < PKT_LEN: pulse err_pad, drop gnt, go to PAD.
- PAD: emit 0x00 with wr_din_en high until PKT_LEN bytes total have been sent, then go to GAP. The output is never an interrupted burst.
- GAP: hold wr_din_en low for GAP cycles, then go to IDLE. A new winner cannot be granted before this.
- Bytes from the non-granted requester, and any din_en in IDLE or GAP, are dropped. err_col pulses for each such cycle.
- The byte count is 8 bits and never exceeds PKT_LEN. It clears on entry to GRANT.
- The wait counter is 7 bits and clears on entry to GRANT.

## Timing
- Reset values: every output is 0, the state is IDLE, last-served is ECM. A reset mid-packet truncates the burst immediately; no padding follows.
- Grant latency: req high in cycle n (state IDLE) gives gnt high in cycle n+1.
- Data latency: wr_din/wr_din_en are registered, one cycle after the accepted din/din_en.
- gnt falls in the cycle after the PKT_LEN-th byte is accepted. The requester must stop driving din_en after PKT_LEN bytes; any further byte counts as err_col.
- Back-to-back packets: at least GAP idle output cycles, plus one IDLE-to-GRANT cycle, between the last byte of one packet and the first byte of the next.
- Error pulses are registered and aligned with the output cycle of the event they flag.

## Structure
- Shared package ddr_wr_pkg holds: PKT_LEN_DEF = 203, ADDR_BYTES = 4, the state enum (IDLE, GRANT, XFER, PAD, GAP), and the requester-ID constants REQ_ECM = 0, REQ_SI = 1. The formatter reuses these.
- Sub-module ddr_wr_rr2: a 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot pick, and pick_id.
  - Purely combinational. The FSM register holds last-served.

## Test plan
- Only ECM requests: first byte at t, 203 contiguous bytes with ecm_din_en -> wr_din_en high for exactly 203 cycles starting t+1, bytes identical; ecm_gnt falls at t+203; busy low GAP+1 cycles after the last byte.
- ecm_req and si_req both rise in the same cycle after reset -> SI granted first; ECM granted after SI's packet plus the gap; no interleaved bytes on wr_din.
- SI packet stops after 50 bytes -> err_pad pulses; 153 bytes of 0x00 follow with wr_din_en kept high; total burst is 203.
- ECM granted but never drives ecm_din_en -> err_tmo at grant+64; ecm_gnt low; SI, pending, granted next.
- ECM drives ecm_din_en during an SI transfer -> err_col each such cycle; the SI output stream is unchanged.
- rst asserted at byte 100 of a packet -> next cycle all outputs 0 and state IDLE; the next packet starts cleanly with its address byte.
